dp_mem_responder: RTL and testbench

- Responder end of the datapath-to-cache request interface. Serves the processor's instruction-fetch and data-read/write requests from an internal word-addressed RAM.
- Each accepted request completes after a programmable wait, signalled by a one-cycle ihit/dhit pulse.
- One access is in service at a time; data requests take priority over instruction fetches.
- Sits where the cache/memory controller connects to the datapath, and serves as the standalone memory model for datapath bring-up.

---
 rtl/dp_mem_responder_if.sv | 41 ++++
 rtl/dp_mem_responder.sv | 123 ++++++++++++
 tb/tb_dp_mem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dp_mem_responder_if.sv
// Datapath-to-memory request bus between the processor datapath (master) and the memory responder (slave).
// With DP_MEM_RESP_STATS_EN defined, the bus also carries the icount/dcount hit counters.
//
// Handshake: imemREN, dmemREN and dmemWEN are levels. The master holds a request, with its address and
// store data stable, until the matching one-cycle ihit/dhit pulse. Dropping a request before its hit
// abandons it. A request still high in the cycle after its hit is taken as a new request.
interface dp_mem_responder_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        halt;
   logic        ihit;
   logic [31:0] imemload;
   logic        dhit;
   logic [31:0] dmemload;
`ifdef DP_MEM_RESP_STATS_EN
   logic [31:0] icount;
   logic [31:0] dcount;

   modport master (
      output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      input  ihit, imemload, dhit, dmemload, icount, dcount
   );
   modport slave (
      input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      output ihit, imemload, dhit, dmemload, icount, dcount
   );
`else
   modport master (
      output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      input  ihit, imemload, dhit, dmemload
   );
   modport slave (
      input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      output ihit, imemload, dhit, dmemload
   );
`endif
endinterface

// File: rtl/dp_mem_responder.sv
// Memory responder: serves one instruction or data access at a time from a word-addressed RAM after LAT wait cycles.
// Optional hit counters (icount/dcount) are enabled by defining DP_MEM_RESP_STATS_EN.
module dp_mem_responder #(
   parameter int LAT   = 2,
   parameter int DEPTH = 1024
) (
   input  logic              CLK,
   input  logic              nRST,
   dp_mem_responder_if.slave bus,
   output logic [1:0]        dbg_state
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAT_CNT = 4'(LAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWAIT = 2'd1,
      IWAIT = 2'd2,
      HIT   = 2'd3
   } state_t;

   state_t         state;
   logic [3:0]     cnt;
   logic           is_instr;
   logic           is_write;
   logic [AW-1:0]  word;
   logic [31:0]    store;
   logic [31:0]    ram [DEPTH];
   logic           req_held;
   logic           finish;
   logic           do_write;
   logic [AW-1:0]  dword;
   logic [AW-1:0]  iword;
   logic           unused_addr_bits;

   assign dword     = bus.dmemaddr[AW+1:2];
   assign iword     = bus.imemaddr[AW+1:2];
   assign unused_addr_bits = ^{bus.dmemaddr[31:AW+2], bus.dmemaddr[1:0],
                               bus.imemaddr[31:AW+2], bus.imemaddr[1:0]};
   assign dbg_state = state;

   // The request that started the access must stay high for it to complete.
   assign req_held = is_instr ? bus.imemREN : (is_write ? bus.dmemWEN : bus.dmemREN);
   assign finish   = (state == DWAIT || state == IWAIT) && req_held && (cnt == 4'd0);
   assign do_write = nRST && finish && is_write;

   // The write lands on the same edge that raises dhit, so a reset before then leaves RAM untouched.
   always_ff @(posedge CLK) begin
      if (do_write) begin
         ram[word] <= store;
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         is_instr     <= 1'b0;
         is_write     <= 1'b0;
         word         <= '0;
         store        <= 32'd0;
         bus.ihit     <= 1'b0;
         bus.dhit     <= 1'b0;
         bus.imemload <= 32'd0;
         bus.dmemload <= 32'd0;
`ifdef DP_MEM_RESP_STATS_EN
         bus.icount   <= 32'd0;
         bus.dcount   <= 32'd0;
`endif
      end else begin
         bus.ihit <= 1'b0;
         bus.dhit <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.dmemREN || bus.dmemWEN) begin
                  is_instr <= 1'b0;
                  is_write <= bus.dmemWEN;
                  word     <= dword;
                  store    <= bus.dmemstore;
                  cnt      <= LAT_CNT;
                  state    <= DWAIT;
               end else if (bus.imemREN && !bus.halt) begin
                  is_instr <= 1'b1;
                  is_write <= 1'b0;
                  word     <= iword;
                  cnt      <= LAT_CNT;
                  state    <= IWAIT;
               end
            end
            DWAIT, IWAIT: begin
               if (!req_held) begin
                  state <= IDLE;
               end else if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state <= HIT;
                  if (is_instr) begin
                     bus.ihit     <= 1'b1;
                     bus.imemload <= ram[word];
`ifdef DP_MEM_RESP_STATS_EN
                     bus.icount   <= bus.icount + 32'd1;
`endif
                  end else begin
                     bus.dhit <= 1'b1;
                     if (!is_write) begin
                        bus.dmemload <= ram[word];
                     end
`ifdef DP_MEM_RESP_STATS_EN
                     bus.dcount <= bus.dcount + 32'd1;
`endif
                  end
               end
            end
            HIT: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dp_mem_responder.sv
// Bench for dp_mem_responder: directed scenarios plus random traffic, checked every cycle against an access-level model.
// Counter checks are included when DP_MEM_RESP_STATS_EN is defined.
module tb_dp_mem_responder;
   localparam int LAT   = 2;
   localparam int DEPTH = 1024;

   logic       CLK;
   logic       nRST;
   logic [1:0] dbg_state;
   int         errors;
   int         checks;

   dp_mem_responder_if bus ();

   dp_mem_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .bus      (bus),
      .dbg_state(dbg_state)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Access-level model: an accepted access completes LAT+1 edges later unless its request drops;
   // the edge after a hit is spent returning to idle.
   typedef enum int {K_IREAD, K_DREAD, K_DWRITE} kind_t;
   logic [31:0] m_mem [DEPTH];
   bit          m_busy;
   bit          m_gap;
   kind_t       m_kind;
   int          m_word;
   logic [31:0] m_data;
   int          m_elapsed;
   logic        m_ihit, m_dhit;
   logic [31:0] m_iload, m_dload, m_icnt, m_dcnt;

   function automatic int word_of(input logic [31:0] a);
      return int'(a >> 2) % DEPTH;
   endfunction

   task automatic model_edge();
      if (!nRST) begin
         m_busy = 0; m_gap = 0; m_ihit = 0; m_dhit = 0;
         m_iload = 0; m_dload = 0; m_icnt = 0; m_dcnt = 0;
      end else begin
         m_ihit = 0;
         m_dhit = 0;
         if (m_gap) begin
            m_gap = 0;
         end else if (m_busy) begin
            if ((m_kind == K_IREAD && !bus.imemREN) || (m_kind == K_DREAD && !bus.dmemREN) ||
                (m_kind == K_DWRITE && !bus.dmemWEN)) begin
               m_busy = 0;
            end else begin
               m_elapsed++;
               if (m_elapsed == LAT + 1) begin
                  case (m_kind)
                     K_IREAD:  begin m_ihit = 1; m_iload = m_mem[m_word]; m_icnt++; end
                     K_DREAD:  begin m_dhit = 1; m_dload = m_mem[m_word]; m_dcnt++; end
                     default:  begin m_dhit = 1; m_mem[m_word] = m_data; m_dcnt++; end
                  endcase
                  m_busy = 0;
                  m_gap  = 1;
               end
            end
         end else if (bus.dmemWEN || bus.dmemREN) begin
            m_busy = 1; m_elapsed = 0;
            m_kind = bus.dmemWEN ? K_DWRITE : K_DREAD;
            m_word = word_of(bus.dmemaddr);
            m_data = bus.dmemstore;
         end else if (bus.imemREN && !bus.halt) begin
            m_busy = 1; m_elapsed = 0;
            m_kind = K_IREAD;
            m_word = word_of(bus.imemaddr);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      chk("ihit", {31'd0, bus.ihit}, {31'd0, m_ihit});
      chk("dhit", {31'd0, bus.dhit}, {31'd0, m_dhit});
      chk("imemload", bus.imemload, m_iload);
      chk("dmemload", bus.dmemload, m_dload);
      chk("hit_exclusive", {31'd0, bus.ihit & bus.dhit}, 32'd0);
`ifdef DP_MEM_RESP_STATS_EN
      chk("icount", bus.icount, m_icnt);
      chk("dcount", bus.dcount, m_dcnt);
`endif
   endtask

   // One clock: the model sees the same edge as the DUT, outputs are compared half a cycle later.
   task automatic step();
      @(posedge CLK);
      model_edge();
      @(negedge CLK);
      compare();
   endtask

   task automatic do_data(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] sdata, output int lat, output logic [31:0] load);
      bus.dmemREN = ren; bus.dmemWEN = wen; bus.dmemaddr = addr; bus.dmemstore = sdata;
      lat = 99; load = 32'hx;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.dhit) begin lat = i; load = bus.dmemload; break; end
      end
      bus.dmemREN = 0; bus.dmemWEN = 0;
      step();
   endtask

   task automatic do_fetch(input logic [31:0] addr, output int lat, output logic [31:0] load);
      bus.imemREN = 1; bus.imemaddr = addr;
      lat = 99; load = 32'hx;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (bus.ihit) begin lat = i; load = bus.imemload; break; end
      end
      bus.imemREN = 0;
      step();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 31));
      return a;
   endfunction

   int          lat, d_at, i_at, seen;
   logic [31:0] ld;
   bit          d_act, i_act;

   initial begin
      errors = 0; checks = 0;
      nRST = 0;
      bus.imemREN = 0; bus.imemaddr = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
      bus.dmemaddr = 0; bus.dmemstore = 0; bus.halt = 0;
      step(); step();
      chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
      chk("rst_dhit", {31'd0, bus.dhit}, 32'd0);
      chk("rst_imemload", bus.imemload, 32'd0);
      chk("rst_dmemload", bus.dmemload, 32'd0);
      nRST = 1;
      step();

      do_data(0, 1, 32'h40, 32'hDEADBEEF, lat, ld);
      chk("wr_lat", lat, 4);
      do_data(1, 0, 32'h40, 32'h0, lat, ld);
      chk("rd_lat", lat, 4);
      chk("rd_data", ld, 32'hDEADBEEF);

      do_data(0, 1, 32'h0, 32'h20010005, lat, ld);
      do_fetch(32'h0, lat, ld);
      chk("if_lat", lat, 4);
      chk("if_data", ld, 32'h20010005);

      // The fetch waits out the data access, the HIT cycle and one idle cycle before it is accepted.
      bus.imemREN = 1; bus.imemaddr = 32'h0; bus.dmemREN = 1; bus.dmemaddr = 32'h40;
      d_at = 99; i_at = 99;
      for (int i = 1; i <= 30; i++) begin
         step();
         if (bus.dhit && d_at == 99) begin d_at = i; bus.dmemREN = 0; end
         if (bus.ihit) begin i_at = i; break; end
      end
      bus.imemREN = 0; bus.dmemREN = 0;
      step();
      chk("prio_dhit_at", d_at, 4);
      chk("prio_ihit_at", i_at, 4 + LAT + 3);

      do_data(0, 1, 32'h80, 32'h11111111, lat, ld);
      bus.dmemWEN = 1; bus.dmemaddr = 32'h80; bus.dmemstore = 32'h12345678;
      step();
      bus.dmemWEN = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin step(); if (bus.dhit) seen++; end
      chk("abort_no_dhit", seen, 0);
      do_data(1, 0, 32'h80, 32'h0, lat, ld);
      chk("abort_old_data", ld, 32'h11111111);

      do_data(0, 1, 32'h1004, 32'hA5A5A5A5, lat, ld);
      do_data(1, 0, 32'h0007, 32'h0, lat, ld);
      chk("alias_data", ld, 32'hA5A5A5A5);

      bus.halt = 1; bus.imemREN = 1; bus.imemaddr = 32'h0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin step(); if (bus.ihit) seen++; end
      chk("halt_no_ihit", seen, 0);
      do_data(1, 0, 32'h40, 32'h0, lat, ld);
      chk("halt_rd_lat", lat, 4);
      chk("halt_rd_data", ld, 32'hDEADBEEF);
      bus.imemREN = 0;
      step();
      bus.halt = 0;

      bus.imemREN = 1; bus.imemaddr = 32'h0;
      lat = 99;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 1) bus.halt = 1;
         if (bus.ihit) begin lat = i; break; end
      end
      bus.imemREN = 0; bus.halt = 0;
      step();
      chk("halt_inflight_lat", lat, 4);

      bus.dmemWEN = 1; bus.dmemaddr = 32'h80; bus.dmemstore = 32'hCAFEF00D;
      step();
      bus.dmemWEN = 0; nRST = 0;
      step();
      chk("midrst_dhit", {31'd0, bus.dhit}, 32'd0);
      chk("midrst_ihit", {31'd0, bus.ihit}, 32'd0);
      chk("midrst_dmemload", bus.dmemload, 32'd0);
      chk("midrst_imemload", bus.imemload, 32'd0);
      nRST = 1;
      step();
      do_data(1, 0, 32'h80, 32'h0, lat, ld);
      chk("midrst_no_write", ld, 32'h11111111);

      for (int w = 0; w < 32; w++) begin
         do_data(0, 1, 32'(w * 4), $urandom, lat, ld);
      end

      d_act = 0; i_act = 0;
      for (int n = 0; n < 3000; n++) begin
         if (d_act) begin
            if ((bus.dhit && $urandom_range(0, 3) != 0) || $urandom_range(0, 40) == 0) begin
               bus.dmemREN = 0; bus.dmemWEN = 0; d_act = 0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       begin bus.dmemREN = 1; bus.dmemWEN = 0; end
               1:       begin bus.dmemREN = 0; bus.dmemWEN = 1; end
               default: begin bus.dmemREN = 1; bus.dmemWEN = 1; end
            endcase
            bus.dmemaddr = rand_addr(); bus.dmemstore = $urandom; d_act = 1;
         end
         if (i_act) begin
            if ((bus.ihit && $urandom_range(0, 3) != 0) || $urandom_range(0, 40) == 0) begin
               bus.imemREN = 0; i_act = 0;
            end
         end else if ($urandom_range(0, 3) == 0) begin
            bus.imemREN = 1; bus.imemaddr = rand_addr(); i_act = 1;
         end
         if ($urandom_range(0, 19) == 0) bus.halt = ~bus.halt;
         nRST = ($urandom_range(0, 299) != 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
